// File: rtl/lb_reg_bank.sv
// lb_reg_bank: addressed, chip-selected bank of local-bus registers for the
// PicoBlaze I/O port bus. Each register has a fixed access mode (RW, RO status,
// write-1-to-clear event flags, self-clearing command pulse). Reads have a fixed
// one-cycle latency, and irq is a registered OR of every W1C register bit.
module lb_reg_bank #(
   parameter int                          DATA_W    = 8,
   parameter int                          NUM_REGS  = 8,
   parameter int                          ADDR_W    = 8,
   parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL = '0,
   parameter logic [2*NUM_REGS-1:0]       MODE      = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cs,
   input  logic                          wr_strobe,
   input  logic                          rd_strobe,
   input  logic [ADDR_W-1:0]             port_id,
   input  logic [DATA_W-1:0]             out_port,
   output logic [DATA_W-1:0]             in_port,
   output logic                          rd_valid,
   input  logic [NUM_REGS*DATA_W-1:0]    hw_in,
   input  logic [NUM_REGS*DATA_W-1:0]    hw_set,
   output logic [NUM_REGS*DATA_W-1:0]    reg_out,
   output logic                          irq
);

   localparam logic [1:0] MODE_RW    = 2'b00;
   localparam logic [1:0] MODE_RO    = 2'b01;
   localparam logic [1:0] MODE_W1C   = 2'b10;
   localparam logic [1:0] MODE_PULSE = 2'b11;

   // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W+1)'(NUM_REGS);

   logic                  wr_hit;
   logic                  rd_hit;
   logic [NUM_REGS-1:0]   w1c_flag;
   logic [DATA_W-1:0]     rd_data;
   logic [DATA_W-1:0]     in_port_reg;
   logic                  rd_valid_reg;
   logic                  irq_reg;

   // Only RO registers consume hw_in and only W1C registers consume hw_set;
   // the remaining slices are intentionally left unused.
   logic                  unused_hw;
   assign unused_hw = ^{hw_in, hw_set};

   assign wr_hit = cs & wr_strobe & ({1'b0, port_id} < NUM_REGS_EXT);
   assign rd_hit = cs & rd_strobe;

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         localparam logic [1:0]        REG_MODE = MODE[2*gi +: 2];
         localparam logic [ADDR_W-1:0] REG_ADDR = ADDR_W'(gi);

         logic              wr_sel;
         logic [DATA_W-1:0] q_reg;

         assign wr_sel = wr_hit && (port_id == REG_ADDR);
         assign reg_out[gi*DATA_W +: DATA_W] = q_reg;

         if (REG_MODE == MODE_RW) begin : g_rw
            // Plain read/write register, loads its reset image slice.
            always_ff @(posedge clk) begin
               if (reset)
                  q_reg <= RESET_VAL[gi*DATA_W +: DATA_W];
               else if (wr_sel)
                  q_reg <= out_port;
            end
            assign w1c_flag[gi] = 1'b0;
         end else if (REG_MODE == MODE_RO) begin : g_ro
            // Status register: samples hardware every cycle, bus writes ignored.
            always_ff @(posedge clk) begin
               if (reset)
                  q_reg <= '0;
               else
                  q_reg <= hw_in[gi*DATA_W +: DATA_W];
            end
            assign w1c_flag[gi] = 1'b0;
         end else if (REG_MODE == MODE_W1C) begin : g_w1c
            // Event flags: hardware sets, bus writes of 1 clear, set wins a tie.
            always_ff @(posedge clk) begin
               if (reset)
                  q_reg <= '0;
               else
                  q_reg <= (q_reg & ~(wr_sel ? out_port : {DATA_W{1'b0}}))
                           | hw_set[gi*DATA_W +: DATA_W];
            end
            assign w1c_flag[gi] = |q_reg;
         end else begin : g_pulse
            // Command pulse: written bits stay high for one cycle only.
            always_ff @(posedge clk) begin
               if (reset)
                  q_reg <= '0;
               else if (wr_sel)
                  q_reg <= out_port;
               else
                  q_reg <= '0;
            end
            assign w1c_flag[gi] = 1'b0;
         end
      end
   endgenerate

   // Read mux: out-of-range addresses and PULSE registers read as zero.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if ((port_id == ADDR_W'(i)) && (MODE[2*i +: 2] != MODE_PULSE))
            rd_data = reg_out[i*DATA_W +: DATA_W];
      end
   end

   // Read pipeline and interrupt request: both one cycle behind the registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_port_reg  <= '0;
         rd_valid_reg <= 1'b0;
         irq_reg      <= 1'b0;
      end else begin
         rd_valid_reg <= rd_hit;
         if (rd_hit)
            in_port_reg <= rd_data;
         irq_reg <= |w1c_flag;
      end
   end

   assign in_port  = in_port_reg;
   assign rd_valid = rd_valid_reg;
   assign irq      = irq_reg;

endmodule

// File: tb/tb_lb_reg_bank.sv
// Testbench for lb_reg_bank: 4 registers -- reg0 RO, reg1 W1C, reg2 RW,
// reg3 PULSE. Read data is checked through a scoreboard queue; register
// contents, irq and rd_valid timing are checked inline in each test task.
module tb_lb_reg_bank;

   localparam int DATA_W   = 8;
   localparam int NUM_REGS = 4;
   localparam int ADDR_W   = 8;
   localparam logic [31:0] RST_IMG = 32'hA5_3C_00_11;
   localparam logic [7:0]  MODES   = 8'b11_00_10_01;
   // Only reg2 is RW, so only its slice of the reset image (0x3C) survives.
   localparam logic [31:0] RESET_EXP = 32'h00_3C_00_00;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cs = 1'b0;
   logic        wr_strobe = 1'b0;
   logic        rd_strobe = 1'b0;
   logic [7:0]  port_id = '0;
   logic [7:0]  out_port = '0;
   logic [7:0]  in_port;
   logic        rd_valid;
   logic [31:0] hw_in = '0;
   logic [31:0] hw_set = '0;
   logic [31:0] reg_out;
   logic        irq;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  rd_queue[$];

   lb_reg_bank #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
      .RESET_VAL(RST_IMG), .MODE(MODES)
   ) dut (
      .clk(clk), .reset(reset), .cs(cs), .wr_strobe(wr_strobe),
      .rd_strobe(rd_strobe), .port_id(port_id), .out_port(out_port),
      .in_port(in_port), .rd_valid(rd_valid), .hw_in(hw_in),
      .hw_set(hw_set), .reg_out(reg_out), .irq(irq)
   );

   always #5 clk = ~clk;

   // Scoreboard consumer: every rd_valid pops one expected read value.
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         n_checks++;
         if (rd_queue.size() == 0) begin
            n_fail++;
            $display("FAIL read_unexpected: rd_valid high with in_port=%h, none expected", in_port);
         end else begin
            logic [7:0] exp_data;
            exp_data = rd_queue.pop_front();
            if (in_port !== exp_data) begin
               n_fail++;
               $display("FAIL read_data: in_port=%h expected=%h", in_port, exp_data);
            end else
               $display("read ok: in_port=%h", in_port);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      cs = 1'b0; wr_strobe = 1'b0; rd_strobe = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
      cs = 1'b1; wr_strobe = 1'b1; port_id = addr; out_port = data;
      tick();
      idle_bus();
      $display("write port=%0d data=%h", addr, data);
   endtask

   task automatic do_read(input logic [7:0] addr, input logic [7:0] exp_data);
      cs = 1'b1; rd_strobe = 1'b1; port_id = addr;
      rd_queue.push_back(exp_data);
      tick();
      idle_bus();
      n_checks++;
      if (rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rd_valid_latency: rd_valid=%b expected=1 (port %0d)", rd_valid, addr);
      end
      tick();
      n_checks++;
      if (rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_valid_width: rd_valid=%b expected=0 (port %0d)", rd_valid, addr);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      n_checks++;
      if (reg_out !== RESET_EXP) begin
         n_fail++;
         $display("FAIL reset_reg_out: reg_out=%h expected=%h", reg_out, RESET_EXP);
      end
      n_checks++;
      if (in_port !== 8'h00 || rd_valid !== 1'b0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: in_port=%h rd_valid=%b irq=%b expected 00/0/0", in_port, rd_valid, irq);
      end
      $display("reset done: reg_out=%h", reg_out);
   endtask

   task automatic test_rw();
      do_write(8'd2, 8'h5A);
      n_checks++;
      if (reg_out[23:16] !== 8'h5A) begin
         n_fail++;
         $display("FAIL rw_write: reg2=%h expected=5A", reg_out[23:16]);
      end
      // Same write with chip select low must be ignored.
      cs = 1'b0; wr_strobe = 1'b1; port_id = 8'd2; out_port = 8'h33;
      tick();
      idle_bus();
      n_checks++;
      if (reg_out[23:16] !== 8'h5A) begin
         n_fail++;
         $display("FAIL rw_cs_gate: reg2=%h expected=5A", reg_out[23:16]);
      end
      do_read(8'd2, 8'h5A);
      // Read and write of the same address together: read sees the old value.
      cs = 1'b1; wr_strobe = 1'b1; rd_strobe = 1'b1; port_id = 8'd2; out_port = 8'h99;
      rd_queue.push_back(8'h5A);
      tick();
      idle_bus();
      n_checks++;
      if (reg_out[23:16] !== 8'h99) begin
         n_fail++;
         $display("FAIL rw_collision_write: reg2=%h expected=99", reg_out[23:16]);
      end
      tick();
      do_read(8'd2, 8'h99);
   endtask

   task automatic test_w1c();
      hw_set[15:8] = 8'h81;
      tick();
      hw_set = '0;
      n_checks++;
      if (reg_out[15:8] !== 8'h81 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL w1c_set: reg1=%h irq=%b expected 81/0", reg_out[15:8], irq);
      end
      tick();
      n_checks++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL w1c_irq_rise: irq=%b expected=1", irq);
      end
      // Clear of bit 0 collides with a set of bit 0: set wins.
      hw_set[15:8] = 8'h01;
      do_write(8'd1, 8'h01);
      hw_set = '0;
      n_checks++;
      if (reg_out[15:8] !== 8'h81) begin
         n_fail++;
         $display("FAIL w1c_collision: reg1=%h expected=81", reg_out[15:8]);
      end
      do_write(8'd1, 8'h80);
      n_checks++;
      if (reg_out[15:8] !== 8'h01) begin
         n_fail++;
         $display("FAIL w1c_partial_clear: reg1=%h expected=01", reg_out[15:8]);
      end
      do_read(8'd1, 8'h01);
      do_write(8'd1, 8'hFF);
      n_checks++;
      if (reg_out[15:8] !== 8'h00 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL w1c_clear: reg1=%h irq=%b expected 00/1", reg_out[15:8], irq);
      end
      tick();
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL w1c_irq_fall: irq=%b expected=0", irq);
      end
   endtask

   task automatic test_pulse();
      do_write(8'd3, 8'h04);
      n_checks++;
      if (reg_out[31:24] !== 8'h04) begin
         n_fail++;
         $display("FAIL pulse_high: reg3=%h expected=04", reg_out[31:24]);
      end
      tick();
      n_checks++;
      if (reg_out[31:24] !== 8'h00) begin
         n_fail++;
         $display("FAIL pulse_low: reg3=%h expected=00", reg_out[31:24]);
      end
      // Back-to-back writes give consecutive high cycles.
      cs = 1'b1; wr_strobe = 1'b1; port_id = 8'd3; out_port = 8'h01;
      tick();
      n_checks++;
      if (reg_out[31:24] !== 8'h01) begin
         n_fail++;
         $display("FAIL pulse_b2b_first: reg3=%h expected=01", reg_out[31:24]);
      end
      out_port = 8'h02;
      tick();
      idle_bus();
      n_checks++;
      if (reg_out[31:24] !== 8'h02) begin
         n_fail++;
         $display("FAIL pulse_b2b_second: reg3=%h expected=02", reg_out[31:24]);
      end
      tick();
      n_checks++;
      if (reg_out[31:24] !== 8'h00) begin
         n_fail++;
         $display("FAIL pulse_b2b_end: reg3=%h expected=00", reg_out[31:24]);
      end
      do_read(8'd3, 8'h00);
   endtask

   task automatic test_ro_range();
      logic [31:0] snap;
      hw_in[7:0] = 8'h77;
      tick();
      n_checks++;
      if (reg_out[7:0] !== 8'h77) begin
         n_fail++;
         $display("FAIL ro_sample: reg0=%h expected=77", reg_out[7:0]);
      end
      do_write(8'd0, 8'h00);
      n_checks++;
      if (reg_out[7:0] !== 8'h77) begin
         n_fail++;
         $display("FAIL ro_write_ignored: reg0=%h expected=77", reg_out[7:0]);
      end
      do_read(8'd0, 8'h77);
      // hw_in reaches the register only after the next edge.
      hw_in[7:0] = 8'h12;
      #1;
      n_checks++;
      if (reg_out[7:0] !== 8'h77) begin
         n_fail++;
         $display("FAIL ro_delay: reg0=%h expected=77", reg_out[7:0]);
      end
      tick();
      n_checks++;
      if (reg_out[7:0] !== 8'h12) begin
         n_fail++;
         $display("FAIL ro_follow: reg0=%h expected=12", reg_out[7:0]);
      end
      do_read(8'd9, 8'h00);
      do_read(8'd4, 8'h00);
      snap = {8'h00, 8'h99, 8'h00, 8'h12};
      do_write(8'd4, 8'hEE);
      do_write(8'd6, 8'hEE);
      n_checks++;
      if (reg_out !== snap) begin
         n_fail++;
         $display("FAIL out_of_range_write: reg_out=%h expected=%h", reg_out, snap);
      end
   endtask

   task automatic test_reset_mid();
      hw_set[15:8] = 8'h10;
      tick();
      hw_set = '0;
      tick();
      n_checks++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_irq_setup: irq=%b expected=1", irq);
      end
      // Reset coincides with a write, a read, a hw_set and a live hw_in.
      reset = 1'b1; cs = 1'b1; wr_strobe = 1'b1; rd_strobe = 1'b1;
      port_id = 8'd2; out_port = 8'hFF; hw_set = 32'hFFFF_FFFF;
      tick();
      reset = 1'b0; idle_bus(); hw_set = '0; hw_in = '0;
      n_checks++;
      if (reg_out !== RESET_EXP) begin
         n_fail++;
         $display("FAIL mid_reset_regs: reg_out=%h expected=%h", reg_out, RESET_EXP);
      end
      n_checks++;
      if (rd_valid !== 1'b0 || irq !== 1'b0 || in_port !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: rd_valid=%b irq=%b in_port=%h expected 0/0/00", rd_valid, irq, in_port);
      end
      tick();
      do_read(8'd2, 8'h3C);
      $display("mid-operation reset done: reg_out=%h", reg_out);
   endtask

   initial begin
      test_reset();
      test_rw();
      test_w1c();
      test_pulse();
      test_ro_range();
      test_reset_mid();
      tick();
      n_checks++;
      if (rd_queue.size() != 0) begin
         n_fail++;
         $display("FAIL read_missing: %0d reads never returned, expected 0", rd_queue.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
